stream_pkt_arbiter: RTL and testbench
=====================================

Name: stream_pkt_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one stream_upsize instance among N_SRC narrow stream sources.
- Grants one source at a time and holds the grant until that source's s_last beat is accepted.
- Forwards beats through a registered output stage with skid buffer to the upsizer's s_* port, tagging each beat with a source ID.
- Per-source enable mask is the configuration interface.

Parameters:
- T_DATA_WIDTH, 8, beat width; must match the downstream upsizer.
- N_SRC, 4, number of requesting sources, >=1.
- ID_WIDTH, (N_SRC>1 ? $clog2(N_SRC) : 1), width of source ID.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- en_i  in  N_SRC  per-source arbitration enable
- s_data_i  in  [N_SRC][T_DATA_WIDTH]  source beats (unpacked array of N_SRC)
- s_last_i  in  N_SRC  end-of-packet per source
- s_valid_i  in  N_SRC  beat valid per source
- s_ready_o  out  N_SRC  beat accept per source
- m_data_o  out  T_DATA_WIDTH  beat to upsizer
- m_last_o  out  1  end-of-packet to upsizer
- m_id_o  out  ID_WIDTH  source index of current beat
- m_valid_o  out  1  beat valid to upsizer
- m_ready_i  in  1  upsizer ready
- busy_o  out  1  grant held (state BUSY)

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk. All state changes on posedge clk.
- Reset values:
  - m_valid_o=0, m_data_o=0, m_last_o=0, m_id_o=0, busy_o=0, s_ready_o=0.
  - state=IDLE; last_grant=N_SRC-1, so source 0 has first priority; skid buffer empty.
- Reset mid-packet discards all held beats and the grant. No partial packet is flushed.
- Handshake: a beat transfers when valid&&ready on the same edge. Once valid is asserted it holds with stable data until accepted.
- State IDLE:
  - s_ready_o all 0.
  - req = s_valid_i & en_i.
  - If req!=0: winner = first set bit searching last_grant+1, +2, ... modulo N_SRC. grant<=winner; state<=BUSY.
  - If req==0: stay in IDLE.
  - Arbitration costs one bubble cycle per packet; no beat transfers in the IDLE cycle.
- State BUSY:
  - s_ready_o[grant] = !skid_valid; all other bits 0.
  - On an accepted input beat with s_last_i[grant]=1: state<=IDLE, last_grant<=grant.
  - s_valid_i[grant] dropping mid-packet: hold the grant and wait indefinitely. No timeout, no preemption.
  - en_i[grant] deasserting mid-packet: no effect until the packet completes. en_i is sampled only in IDLE.
- Output stage: main register (m_*) plus one-entry skid register.
  - Accepted beat goes to main if main is empty or main drains that cycle; otherwise to skid.
  - When main drains and skid is valid, skid moves to main.
  - Sustained throughput is 1 beat/cycle. Input-to-m_valid_o latency is 1 cycle.
  - s_ready_o is a function of registered state only; no combinational path from m_ready_i.
- m_id_o, m_last_o and m_data_o travel together with each beat.
- Packet of L beats, no stall: first beat at m_* on cycle 2 after arbitration starts; last beat on cycle L+1.
- Back-to-back packets from different sources: exactly one bubble between them at the input side. The output may close the bubble if stalled.
- Single-beat packet (s_last on first beat): BUSY for one cycle, then IDLE.
- Downstream stall (m_ready_i=0): main and skid fill, s_ready_o drops, no beat lost or duplicated.
- en_i=0 for all sources: stay in IDLE, outputs drain normally.
- N_SRC=1: degenerates to a pass-through with one arbitration bubble per packet; m_id_o=0.

Decomposition:
- Package stream_pkg:
  - typedef enum logic {IDLE, BUSY} arb_state_t.
  - Function rr_pick(req, last_grant) returning the round-robin winner index.
  - Shared beat struct {data, last, id} parameterised by width localparams.
- Sub-module stream_skid_buffer (data+last+id payload, 2-entry): reusable, and a natural split from the grant FSM.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with all s_valid_i=1 -> m_valid_o=0 and s_ready_o=0 throughout; first grant after release goes to source 0.
- Fairness: sources 0..3 each continuously offer 2-beat packets, m_ready_i=1 -> m_id_o sequence 0,0,1,1,2,2,3,3,0,0; one bubble between packets.
- Lock: source 1 sends a 4-beat packet with s_valid_i[1] low for 2 cycles mid-packet while source 2 is valid -> all 4 beats tagged id 1 and contiguous in order before any id-2 beat.
- Backpressure: 8-beat packet (data 0x10..0x17), m_ready_i toggled 1,0,0,1 pattern -> output data exactly 0x10..0x17, m_last_o only on 0x17, s_ready_o low while skid full.
- Enable mask: en_i=4'b0101 with all sources valid -> grants alternate 0,2,0,2; en_i[0] cleared mid-packet of source 0 -> packet completes, next grant 2.
- Reset mid-packet: rst_n=0 after beat 2 of a 5-beat packet -> outputs return to reset values next edge; after release, arbitration restarts from source 0.

Source files
------------

// File: rtl/stream_pkg.sv
// Shared types and helpers for the packet arbiter and its output stage.
package stream_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  // Upper bound on the number of sources rr_pick can scan.
  localparam int unsigned MaxSrc   = 32;
  localparam int unsigned SelWidth = $clog2(MaxSrc);

  // Beat as seen on the upsizer side, sized for the default configuration.
  localparam int unsigned BeatDataWidth = 8;
  localparam int unsigned BeatIdWidth   = 2;

  typedef struct packed {
    logic [BeatIdWidth-1:0]   id;
    logic                     last;
    logic [BeatDataWidth-1:0] data;
  } beat_t;

  // Round-robin winner: first requester after last_grant, wrapping modulo n_src.
  // With no request the previous grant is returned unchanged.
  function automatic int unsigned rr_pick(input logic [MaxSrc-1:0] req,
                                          input int unsigned       last_grant,
                                          input int unsigned       n_src);
    int unsigned idx;
    rr_pick = last_grant;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int unsigned off = MaxSrc; off > 0; off--) begin
      if (off <= n_src) begin
        idx = (last_grant + off) % n_src;
        if (req[idx[SelWidth-1:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry registered output stage: main register plus one skid slot.
// in_ready_o depends only on registered state, so no path from out_ready_i.
module stream_skid_buffer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             in_ready_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  input  logic             out_ready_i
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             push, pop;

  assign in_ready_o  = !skid_valid_q;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_data_q;
  assign push        = in_valid_i && !skid_valid_q;
  assign pop         = main_valid_q && out_ready_i;

  // Next-state: refill main from skid on drain, land new beats in main when it frees up.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (pop) begin
      if (skid_valid_q) begin
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        main_valid_d = 1'b0;
      end
    end
    // push implies skid empty, so a drain above never collides with it.
    if (push) begin
      if (!main_valid_q || pop) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data_i;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end
    end
  end

  // Storage registers; reset drops anything held.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one upsizer through a skid stage.
// A grant is held from the first beat until that source's last beat is accepted.
module stream_pkt_arbiter #(
  parameter int unsigned T_DATA_WIDTH = 8,
  parameter int unsigned N_SRC        = 4,
  parameter int unsigned ID_WIDTH     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        en_i,
  input  logic [T_DATA_WIDTH-1:0] s_data_i [N_SRC],
  input  logic [N_SRC-1:0]        s_last_i,
  input  logic [N_SRC-1:0]        s_valid_i,
  output logic [N_SRC-1:0]        s_ready_o,
  output logic [T_DATA_WIDTH-1:0] m_data_o,
  output logic                    m_last_o,
  output logic [ID_WIDTH-1:0]     m_id_o,
  output logic                    m_valid_o,
  input  logic                    m_ready_i,
  output logic                    busy_o
);

  import stream_pkg::*;

  localparam int unsigned PayloadW = ID_WIDTH + 1 + T_DATA_WIDTH;

  arb_state_t              state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q, grant_d;
  logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
  logic [N_SRC-1:0]        req;
  logic                    sel_valid, sel_last;
  logic [T_DATA_WIDTH-1:0] sel_data;
  logic                    in_valid, in_ready, accept;
  logic [PayloadW-1:0]     in_payload, out_payload;

  // Mux the granted source onto the output stage input.
  always_comb begin
    req        = s_valid_i & en_i;
    sel_valid  = s_valid_i[grant_q];
    sel_last   = s_last_i[grant_q];
    sel_data   = s_data_i[grant_q];
    in_valid   = (state_q == BUSY) && sel_valid;
    accept     = in_valid && in_ready;
    in_payload = {grant_q, sel_last, sel_data};
  end

  // Ready only toward the granted source, gated by skid occupancy.
  always_comb begin
    s_ready_o = '0;
    if (state_q == BUSY) s_ready_o[grant_q] = in_ready;
  end

  // Grant FSM: arbitrate in IDLE (one bubble), hold the grant until the last beat.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = ID_WIDTH'(rr_pick(MaxSrc'(req), 32'(last_grant_q), N_SRC));
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept && sel_last) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Arbitration state; last_grant starts at N_SRC-1 so source 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_WIDTH'(N_SRC - 1);
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

  stream_skid_buffer #(
    .WIDTH (PayloadW)
  ) u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (in_valid),
    .in_data_i   (in_payload),
    .in_ready_o  (in_ready),
    .out_valid_o (m_valid_o),
    .out_data_o  (out_payload),
    .out_ready_i (m_ready_i)
  );

  assign {m_id_o, m_last_o, m_data_o} = out_payload;
  assign busy_o = (state_q == BUSY);

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Self-checking bench: per-source packet queues, a queue-based round-robin
// model producing the expected output beat order, and directed scenarios.
module tb_stream_pkt_arbiter;
  import stream_pkg::*;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  en_i;
  logic [W-1:0]  s_data_i [N];
  logic [N-1:0]  s_last_i, s_valid_i, s_ready_o;
  logic [W-1:0]  m_data_o;
  logic          m_last_o;
  logic [IW-1:0] m_id_o;
  logic          m_valid_o, m_ready_i, busy_o;

  always #5 clk = ~clk;

  stream_pkt_arbiter #(
    .T_DATA_WIDTH (W),
    .N_SRC        (N),
    .ID_WIDTH     (IW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en_i      (en_i),
    .s_data_i  (s_data_i),
    .s_last_i  (s_last_i),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .m_data_o  (m_data_o),
    .m_last_o  (m_last_o),
    .m_id_o    (m_id_o),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .busy_o    (busy_o)
  );

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
    logic [3:0]   delay;  // cycles valid stays low before this beat is offered
  } src_beat_t;

  src_beat_t src_q [N][$];
  src_beat_t mdl_q [N][$];
  beat_t     exp_q [$];
  int        mdl_last;
  int        n_checks, n_errors;
  int        first_fire, last_fire, first_mv, max_held, n_beats, n_pkts;

  task automatic clear_queues();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    mdl_last = N - 1;
    n_beats  = 0;
    n_pkts   = 0;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    s_valid_i = '0;
    s_last_i  = '0;
    m_ready_i = 1'b0;
    en_i      = '1;
    for (int i = 0; i < N; i++) s_data_i[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_queues();
  endtask

  task automatic add_packet(input int src, input int len, input logic [W-1:0] base,
                            input bit rnd_data, input int gap_beat, input int gap_len,
                            input int gap_pct);
    src_beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = rnd_data ? W'($urandom) : W'(int'(base) + k);
      b.last  = (k == len - 1);
      b.delay = 4'd0;
      if (k == gap_beat) b.delay = 4'(gap_len);
      else if (k > 0 && int'($urandom_range(99)) < gap_pct) b.delay = 4'($urandom_range(1, 2));
      src_q[src].push_back(b);
      mdl_q[src].push_back(b);
    end
    n_beats += len;
    n_pkts++;
  endtask

  // Whole packets leave in round-robin order among enabled sources with pending work.
  task automatic model_arb(input logic [N-1:0] en, input int max_pkts);
    src_beat_t sb;
    beat_t     ob;
    int        win, c;
    for (int p = 0; p < max_pkts; p++) begin
      win = -1;
      for (int off = 1; off <= N; off++) begin
        c = (mdl_last + off) % N;
        if (win < 0 && en[c] && mdl_q[c].size() > 0) win = c;
      end
      if (win < 0) break;
      do begin
        sb      = mdl_q[win].pop_front();
        ob.id   = IW'(win);
        ob.data = sb.data;
        ob.last = sb.last;
        exp_q.push_back(ob);
      end while (!sb.last);
      mdl_last = win;
    end
  endtask

  // Drives source queues and downstream ready, scoreboards every output beat.
  task automatic run_traffic(input string tag, input int ready_pct, input bit use_pat,
                             input logic [3:0] ready_pat, input int en_cyc,
                             input logic [N-1:0] en_late, input int budget);
    int           cyc, held;
    int           wait_cnt [N];
    logic [N-1:0] fire;
    logic         mf;
    beat_t        got, want;
    cyc = 0; held = 0; first_fire = -1; last_fire = -1; first_mv = -1; max_held = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    while (cyc < budget && (exp_q.size() > 0 || held > 0)) begin
      if (cyc == en_cyc) en_i = en_late;
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() > 0 && wait_cnt[i] == 0) begin
          s_valid_i[i] = 1'b1;
          s_data_i[i]  = src_q[i][0].data;
          s_last_i[i]  = src_q[i][0].last;
        end else begin
          s_valid_i[i] = 1'b0;
          s_data_i[i]  = W'($urandom);
          s_last_i[i]  = 1'($urandom);
        end
      end
      m_ready_i = use_pat ? ready_pat[cyc % 4] : (int'($urandom_range(99)) < ready_pct);
      if (first_mv < 0 && m_valid_o) first_mv = cyc;
      n_checks++;
      if ($countones(s_ready_o) > 1) begin
        n_errors++;
        $display("FAIL %s onehot_ready cyc=%0d: s_ready_o=%b, want at most one bit", tag, cyc,
                 s_ready_o);
      end
      n_checks++;
      if (held == 2 && s_ready_o != '0) begin
        n_errors++;
        $display("FAIL %s ready_while_full cyc=%0d: s_ready_o=%b, want 0000", tag, cyc,
                 s_ready_o);
      end
      n_checks++;
      if (m_valid_o !== (held > 0)) begin
        n_errors++;
        $display("FAIL %s mvalid_occupancy cyc=%0d: m_valid_o=%b, want %b (held=%0d)", tag, cyc,
                 m_valid_o, held > 0, held);
      end
      fire = s_valid_i & s_ready_o;
      mf   = m_valid_o && m_ready_i;
      if (mf) begin
        got.id = m_id_o; got.last = m_last_o; got.data = m_data_o;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL %s extra_beat cyc=%0d: got id=%0d data=%02h, want no beat", tag, cyc,
                   got.id, got.data);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            n_errors++;
            $display("FAIL %s beat cyc=%0d: got id=%0d last=%b data=%02h, want id=%0d last=%b data=%02h",
                     tag, cyc, got.id, got.last, got.data, want.id, want.last, want.data);
          end
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (fire[i]) begin
          void'(src_q[i].pop_front());
          if (src_q[i].size() > 0) wait_cnt[i] = int'(src_q[i][0].delay);
          if (first_fire < 0) first_fire = cyc;
          last_fire = cyc;
          held++;
        end else if (!s_valid_i[i] && wait_cnt[i] > 0) begin
          wait_cnt[i]--;
        end
      end
      if (mf) held--;
      if (held > max_held) max_held = held;
      cyc++;
    end
    n_checks++;
    if (exp_q.size() != 0 || held != 0) begin
      n_errors++;
      $display("FAIL %s drain: %0d beats outstanding, %0d held after %0d cycles, want 0 and 0",
               tag, exp_q.size(), held, cyc);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    en_i      = '1;
    s_valid_i = '1;
    s_last_i  = '0;
    m_ready_i = 1'b1;
    for (int i = 0; i < N; i++) s_data_i[i] = W'($urandom);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if ({m_valid_o, m_last_o, m_id_o, m_data_o} !== '0) begin
        n_errors++;
        $display("FAIL reset_outputs c=%0d: valid=%b last=%b id=%0d data=%02h, want all 0", c,
                 m_valid_o, m_last_o, m_id_o, m_data_o);
      end
      n_checks++;
      if ({busy_o, s_ready_o} !== '0) begin
        n_errors++;
        $display("FAIL reset_ready c=%0d: busy=%b s_ready=%b, want 0 0000", c, busy_o, s_ready_o);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy_o !== 1'b1 || s_ready_o !== 4'b0001 || m_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_first_grant: busy=%b s_ready=%b m_valid=%b, want 1 0001 0", busy_o,
               s_ready_o, m_valid_o);
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 2; p++) add_packet(s, 2, 8'h00, 1'b1, -1, 0, 0);
    model_arb('1, 100);
    run_traffic("fair", 100, 1'b0, 4'b0, -1, '0, 400);
    n_checks++;
    if (first_mv != 2) begin
      n_errors++;
      $display("FAIL fair_latency: first m_valid at cycle %0d, want 2", first_mv);
    end
    n_checks++;
    if (first_fire != 1 || last_fire - first_fire + 1 != n_beats + n_pkts - 1) begin
      n_errors++;
      $display("FAIL fair_bubbles: input span %0d..%0d, want 1..%0d", first_fire, last_fire,
               n_beats + n_pkts - 1);
    end
  endtask

  task automatic test_lock();
    apply_reset();
    add_packet(1, 4, 8'h40, 1'b0, 2, 2, 0);
    add_packet(2, 3, 8'h50, 1'b0, -1, 0, 0);
    model_arb('1, 100);
    run_traffic("lock", 100, 1'b0, 4'b0, -1, '0, 200);
    // 2 beats, 2-cycle gap, 2 beats, 1 bubble, 3 beats
    n_checks++;
    if (last_fire - first_fire + 1 != 10) begin
      n_errors++;
      $display("FAIL lock_span: input span %0d cycles, want 10", last_fire - first_fire + 1);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    add_packet(0, 8, 8'h10, 1'b0, -1, 0, 0);
    model_arb('1, 100);
    run_traffic("bp", 0, 1'b1, 4'b1001, -1, '0, 200);
    n_checks++;
    if (max_held != 2) begin
      n_errors++;
      $display("FAIL bp_skid_used: peak occupancy %0d, want 2", max_held);
    end
  endtask

  task automatic test_enable();
    apply_reset();
    for (int s = 0; s < N; s++)
      for (int p = 0; p < 2; p++) add_packet(s, int'($urandom_range(1, 4)), 8'h00, 1'b1, -1, 0, 0);
    en_i = 4'b0101;
    model_arb(4'b0101, 100);
    run_traffic("en_mask", 100, 1'b0, 4'b0, -1, '0, 300);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (busy_o !== 1'b0 || s_ready_o !== '0) begin
        n_errors++;
        $display("FAIL en_masked_idle c=%0d: busy=%b s_ready=%b, want 0 0000", c, busy_o,
                 s_ready_o);
      end
    end
    apply_reset();
    add_packet(0, 4, 8'h60, 1'b0, -1, 0, 0);
    add_packet(0, 4, 8'h64, 1'b0, -1, 0, 0);
    add_packet(2, 3, 8'h70, 1'b0, -1, 0, 0);
    add_packet(2, 3, 8'h73, 1'b0, -1, 0, 0);
    model_arb(4'b0101, 1);
    model_arb(4'b0100, 100);
    en_i = 4'b0101;
    run_traffic("en_clear", 100, 1'b0, 4'b0, 3, 4'b0100, 300);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    s_valid_i   = 4'b0010;
    s_data_i[1] = 8'hA0;
    m_ready_i   = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    s_data_i[1] = 8'hA1;
    @(posedge clk);
    #1;
    n_checks++;
    if (m_valid_o !== 1'b1 || m_data_o !== 8'hA1 || m_id_o !== 2'd1) begin
      n_errors++;
      $display("FAIL rmid_pre: valid=%b data=%02h id=%0d, want 1 a1 1", m_valid_o, m_data_o,
               m_id_o);
    end
    s_data_i[1] = 8'hA2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if ({m_valid_o, m_last_o, m_id_o, m_data_o, busy_o, s_ready_o} !== '0) begin
      n_errors++;
      $display("FAIL rmid_reset: valid=%b last=%b id=%0d data=%02h busy=%b s_ready=%b, want all 0",
               m_valid_o, m_last_o, m_id_o, m_data_o, busy_o, s_ready_o);
    end
    s_valid_i = 4'b0011;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_checks++;
    if (busy_o !== 1'b1 || s_ready_o !== 4'b0001 || m_valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_restart: busy=%b s_ready=%b m_valid=%b, want 1 0001 0", busy_o,
               s_ready_o, m_valid_o);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] en;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      en = N'($urandom_range(1, 15));
      for (int s = 0; s < N; s++) begin
        int np;
        np = int'($urandom_range(0, 3));
        for (int p = 0; p < np; p++) add_packet(s, int'($urandom_range(1, 6)), 8'h00, 1'b1, -1, 0, 30);
      end
      model_arb(en, 1000);
      en_i = en;
      run_traffic($sformatf("rand%0d", r), int'($urandom_range(30, 100)), 1'b0, 4'b0, -1, '0,
                  2000);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want normal finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    mdl_last = N - 1;
    test_reset();
    test_fairness();
    test_lock();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
